parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial frame receiver that checks the XOR parity bit appended by the team's parity-generating transmitter. It deserialises a start bit, DATA_W data bits (LSB first) and one parity bit, and recomputes parity with a running XOR. It presents the word with a one-cycle valid strobe and a parity-error flag, and keeps a saturating error count. It sits at the receive end of the serial link, between the bit-level line interface and the word-level consumer.

## Interface
- DATA_W, 8, data bits per frame (≥2)
- ODD, 0, 0 = even parity, 1 = odd parity
- TIMEOUT, 16, idle cycles tolerated mid-frame before abort (used only with FRAME_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sin  in  1  serial data bit
- sin_valid  in  1  sin is sampled only on edges where this is 1
- data_out  out  DATA_W  last completed word; held until next completion
- data_valid  out  1  one-cycle pulse, frame completed
- parity_err  out  1  valid only with data_valid; 1 = parity mismatch, else 0
- frame_abort  out  1  one-cycle pulse, frame dropped on timeout
- busy  out  1  1 while state ≠ IDLE
- err_count  out  8  saturating count of parity errors

## Operation
- States: IDLE, DATA, PARITY.
- IDLE: if sin_valid=1 and sin=0 (start bit), go to DATA with bit_cnt=0 and par=0. If sin_valid=1 and sin=1 (line idle), ignore it.
- DATA: on each sin_valid, shift sin into shift_reg[bit_cnt] (LSB first) and set par ^= sin. On the DATA_W-th valid bit, go to PARITY.
- PARITY: on sin_valid, compute chk = par ^ sin ^ ODD, then go to IDLE and register:
  - data_out = shift_reg
  - data_valid = 1
  - parity_err = chk
  - if chk=1 and err_count<255, increment err_count
- Cycles with sin_valid=0 in any state do not change state, bit_cnt or par. Gaps in sin_valid of any length are legal without the macro.
- Width rules:
  - bit_cnt is $clog2(DATA_W+1) bits wide.
  - err_count saturates at 8'hFF and never wraps.
- A frame with a parity error still delivers data_out. Consumers gate on parity_err.
- Reset mid-frame drops the partial frame and produces no data_valid or frame_abort.

## Timing
- Reset values:
  - state = IDLE
  - data_out = 0
  - data_valid = 0
  - parity_err = 0
  - frame_abort = 0
  - busy = 0
  - err_count = 0
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: data_valid and parity_err are high for exactly the cycle after the edge that samples the parity bit.
- A minimum frame is DATA_W+2 valid cycles. Back-to-back frames are supported: a start bit presented in the same cycle data_valid is high is accepted.
- busy rises the cycle after the start bit is sampled and falls together with the data_valid or frame_abort pulse.
- data_valid and frame_abort are never high in the same cycle.
- rst has priority over every other input on the same edge.

## Configuration
- FRAME_TIMEOUT_EN defined:
  - In DATA and PARITY, an idle counter increments on each cycle with sin_valid=0 and clears on each sin_valid=1.
  - When the counter reaches TIMEOUT, the block returns to IDLE, pulses frame_abort for one cycle, and does not update data_out or err_count.
  - A sin_valid arriving on the same edge the count reaches TIMEOUT wins: the bit is taken and there is no abort.
- FRAME_TIMEOUT_EN undefined:
  - No idle counter is built.
  - frame_abort is tied to 0.
  - The block waits indefinitely mid-frame.

## Test plan
- Even parity, DATA_W=8: send start 0, bits 1,0,1,0,0,1,0,1, parity 0, all with sin_valid=1 -> data_out=8'hA5, data_valid high 1 cycle, parity_err=0, err_count=0.
- Same frame with parity bit 1 -> data_out=8'hA5, parity_err=1, err_count=1. With ODD=1, the same frame with parity bit 1 -> parity_err=0.
- Frame 8'h3C sent with random sin_valid gaps of 0–5 cycles, and idle 1s with sin_valid=1 before the start bit -> data_out=8'h3C, exactly one data_valid. A second start bit in the data_valid cycle is received correctly.
- Assert rst after 4 data bits, then send a full 8'h5A frame -> no data_valid for the aborted frame, data_out=8'h5A afterward, err_count unchanged.
- Send 260 frames with bad parity -> err_count stops at 8'hFF. Then rst -> err_count=0.
- With FRAME_TIMEOUT_EN and TIMEOUT=16: stop sin_valid for 16 cycles after 3 data bits -> frame_abort pulses once, busy=0, no data_valid. A 15-cycle gap followed by the remaining bits completes the frame normally.

Source files
------------

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver with XOR parity check.
// The frame is a start bit (0), DATA_W data bits sent LSB first, then one parity bit.
// Each completed word is presented with a one-cycle data_valid strobe and a parity_err flag.
// A saturating 8-bit counter tracks how many frames arrived with bad parity.
// Optional feature macro: FRAME_TIMEOUT_EN. When it is defined, a frame is aborted after
// TIMEOUT consecutive cycles without sin_valid while a frame is in progress.
module parity_frame_rx #(
    parameter int DATA_W  = 8,
    parameter int ODD     = 0,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_abort,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int   CNT_W   = $clog2(DATA_W + 1);
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                parity_err_q, parity_err_d;
    logic [7:0]          err_count_q, err_count_d;
    logic                chk;

`ifdef FRAME_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                frame_abort_q, frame_abort_d;
`endif

    // Next-state logic: framing, deserialisation, parity check and optional timeout abort
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        err_count_d  = err_count_q;
        // Running data parity folded with the received parity bit and the parity sense
        chk          = par_q ^ sin ^ ODD_BIT;
`ifdef FRAME_TIMEOUT_EN
        idle_d        = idle_q;
        frame_abort_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // A 1 with sin_valid is the idle line level and is ignored
                if (sin_valid && !sin) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                end
            end
            DATA: begin
                if (sin_valid) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_cnt_q == CNT_W'(i)) begin
                            shift_d[i] = sin;
                        end
                    end
                    par_d     = par_q ^ sin;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sin_valid) begin
                    state_d      = IDLE;
                    // The word is delivered even on a parity error; consumers gate on parity_err
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                    parity_err_d = chk;
                    if (chk && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef FRAME_TIMEOUT_EN
        // A valid bit always clears the idle count, so a bit on the expiry edge wins
        if (sin_valid) begin
            idle_d = '0;
        end else if (state_q != IDLE) begin
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                idle_d        = '0;
                state_d       = IDLE;
                frame_abort_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
    end

    // Control and output registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            err_count_q   <= 8'd0;
`ifdef FRAME_TIMEOUT_EN
            idle_q        <= '0;
            frame_abort_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            parity_err_q  <= parity_err_d;
            err_count_q   <= err_count_d;
`ifdef FRAME_TIMEOUT_EN
            idle_q        <= idle_d;
            frame_abort_q <= frame_abort_d;
`endif
        end
    end

    // Frame working registers; always initialised on the start bit, so they need no reset
    always_ff @(posedge clk) begin
        bit_cnt_q <= bit_cnt_d;
        par_q     <= par_d;
        shift_q   <= shift_d;
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign err_count  = err_count_q;
    assign busy       = (state_q != IDLE);

`ifdef FRAME_TIMEOUT_EN
    assign frame_abort = frame_abort_q;
`else
    // Without the timeout the receiver waits forever mid-frame and never aborts
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign frame_abort    = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Testbench for parity_frame_rx: an even-parity and an odd-parity instance share one
// serial stream and are compared every cycle against a queue-based frame model.
module tb_parity_frame_rx;

    localparam int DW = 8;
    localparam int TO = 16;
`ifdef FRAME_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          sin;
    logic          sin_valid;
    logic [DW-1:0] dout_e, dout_o;
    logic          dv_e, dv_o, pe_e, pe_o, ab_e, ab_o, busy_e, busy_o;
    logic [7:0]    cnt_e, cnt_o;

    parity_frame_rx #(.DATA_W(DW), .ODD(0), .TIMEOUT(TO)) dut_e (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e),
        .frame_abort(ab_e), .busy(busy_e), .err_count(cnt_e)
    );

    parity_frame_rx #(.DATA_W(DW), .ODD(1), .TIMEOUT(TO)) dut_o (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o),
        .frame_abort(ab_o), .busy(busy_o), .err_count(cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame-level view of the bit stream
    bit            m_in_frame = 1'b0;
    bit            m_bits[$];
    int            m_idle = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_valid = 1'b0;
    bit            m_abort = 1'b0;
    bit            m_perr[2] = '{1'b0, 1'b0};
    int            m_cnt[2]  = '{0, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit v);
        int ones;
        m_valid = 1'b0;
        m_abort = 1'b0;
        m_perr  = '{1'b0, 1'b0};
        if (r) begin
            m_in_frame = 1'b0;
            m_bits.delete();
            m_idle = 0;
            m_data = '0;
            m_cnt  = '{0, 0};
        end else if (v) begin
            m_idle = 0;
            if (!m_in_frame) begin
                if (!s) begin
                    m_in_frame = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(s);
                if (m_bits.size() == DW + 1) begin
                    ones = 0;
                    foreach (m_bits[i]) ones += int'(m_bits[i]);
                    for (int i = 0; i < DW; i++) m_data[i] = m_bits[i];
                    m_valid = 1'b1;
                    for (int k = 0; k < 2; k++) begin
                        m_perr[k] = ((ones + k) % 2) == 1;
                        if (m_perr[k] && m_cnt[k] < 255) m_cnt[k]++;
                    end
                    m_in_frame = 1'b0;
                end
            end
        end else if (m_in_frame && TO_EN) begin
            m_idle++;
            if (m_idle == TO) begin
                m_abort    = 1'b1;
                m_in_frame = 1'b0;
                m_idle     = 0;
            end
        end
    endtask

    task automatic check_all();
        check_eq("dv_e",   dv_e,   m_valid);
        check_eq("dv_o",   dv_o,   m_valid);
        check_eq("pe_e",   pe_e,   m_perr[0]);
        check_eq("pe_o",   pe_o,   m_perr[1]);
        check_eq("dout_e", dout_e, m_data);
        check_eq("dout_o", dout_o, m_data);
        check_eq("cnt_e",  cnt_e,  m_cnt[0]);
        check_eq("cnt_o",  cnt_o,  m_cnt[1]);
        check_eq("busy_e", busy_e, m_in_frame);
        check_eq("busy_o", busy_o, m_in_frame);
        check_eq("ab_e",   ab_e,   m_abort);
        check_eq("ab_o",   ab_o,   m_abort);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check on the falling edge
    task automatic cycle(input bit r, input bit s, input bit v);
        rst       = r;
        sin       = s;
        sin_valid = v;
        @(posedge clk);
        model_step(r, s, v);
        @(negedge clk);
        check_all();
    endtask

    task automatic send_bit(input bit b, input int maxgap);
        repeat ($urandom_range(maxgap)) cycle(1'b0, 1'($urandom), 1'b0);
        cycle(1'b0, b, 1'b1);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit pbit, input int maxgap);
        send_bit(1'b0, maxgap);
        for (int i = 0; i < DW; i++) send_bit(d[i], maxgap);
        send_bit(pbit, maxgap);
    endtask

    initial begin
        logic [DW-1:0] d;
        rst = 1'b1;
        sin = 1'b1;
        sin_valid = 1'b0;

        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        check_eq("rst_busy", busy_e, 0);
        check_eq("rst_dout", dout_e, 0);
        check_eq("rst_cnt",  cnt_e,  0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0);

        // A5 with correct even parity, no gaps
        send_frame(8'hA5, 1'b0, 0);
        check_eq("a5_dv",   dv_e,   1);
        check_eq("a5_dout", dout_e, 8'hA5);
        check_eq("a5_pe",   pe_e,   0);
        check_eq("a5_cnt",  cnt_e,  0);
        cycle(1'b0, 1'b1, 1'b1);
        check_eq("a5_dv_drop", dv_e, 0);

        // Same frame with parity bit 1: even flags it, odd accepts it
        send_frame(8'hA5, 1'b1, 0);
        check_eq("a5b_dout", dout_e, 8'hA5);
        check_eq("a5b_pe_e", pe_e,   1);
        check_eq("a5b_cnt",  cnt_e,  1);
        check_eq("a5b_pe_o", pe_o,   0);

        // Idle ones, then 3C with random gaps, then a back-to-back frame
        repeat (4) cycle(1'b0, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 5);
        check_eq("3c_dout", dout_e, 8'h3C);
        send_frame(8'hC3, 1'b0, 0);
        check_eq("b2b_dout", dout_e, 8'hC3);
        check_eq("b2b_dv",   dv_e,   1);

        // Reset after four data bits, then a clean 5A frame
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 2);
        cycle(1'b1, 1'b0, 1'b1);
        check_eq("midrst_busy", busy_e, 0);
        send_frame(8'h5A, 1'b0, 2);
        check_eq("5a_dout", dout_e, 8'h5A);
        check_eq("5a_pe",   pe_e,   0);

        // Saturation of the error counter
        for (int f = 0; f < 260; f++) begin
            d = 8'($urandom);
            send_frame(d, ~(^d), 0);
        end
        check_eq("sat_cnt", cnt_e, 8'hFF);
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("sat_rst", cnt_e, 0);

`ifdef FRAME_TIMEOUT_EN
        // 16-cycle stall after three data bits aborts the frame
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        repeat (TO) cycle(1'b0, 1'b0, 1'b0);
        check_eq("to_abort", ab_e,   1);
        check_eq("to_busy",  busy_e, 0);
        check_eq("to_dv",    dv_e,   0);
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("to_abort_drop", ab_e, 0);

        // 15-cycle stall is tolerated
        d = 8'h96;
        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(d[i], 0);
        repeat (TO - 1) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 3; i < DW; i++) send_bit(d[i], 0);
        send_bit(1'b0, 0);
        check_eq("to15_dv",   dv_e,   1);
        check_eq("to15_dout", dout_e, 8'h96);
`endif

        // Random frames, parity and gaps; occasional long stalls
        for (int f = 0; f < 150; f++) begin
            repeat ($urandom_range(2)) cycle(1'b0, 1'b1, 1'b1);
            send_frame(8'($urandom), 1'($urandom),
                       ($urandom_range(9) == 0) ? 20 : int'($urandom_range(3)));
        end
        repeat (TO + 2) cycle(1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
